// File: rtl/ds_tone_gen.sv
// ds_tone_gen: triangle-wave test tone encoded as a 1-bit first-order
// delta-sigma stream, one bit per DIV clocks, with fixed or swept frequency.
module ds_tone_gen #(
    parameter int DIV     = 32,   // clocks per output bit, power of 2, >= 2
    parameter int PHASE_W = 12,   // phase accumulator width
    parameter int DWELL   = 256   // sample periods per sweep step, power of 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       sweep,
    input  logic [5:0] freq_word,
    input  logic [1:0] amp,
    output logic       ds_out,
    output logic       sample_stb,
    output logic [5:0] step_idx,
    output logic       sweep_wrap
);

    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int TW  = PHASE_W - 1;   // triangle magnitude width
    localparam int AW  = PHASE_W + 1;   // modulator sum width
    localparam logic [AW-1:0] HALF = AW'(2 ** (PHASE_W - 2));

    typedef enum logic [1:0] {IDLE, FIXED, SWEEP} state_t;

    state_t                 state, state_nxt;
    logic [DCW-1:0]         div_cnt;
    logic [DWW-1:0]         dwell_cnt;
    logic [PHASE_W-1:0]     phase;
    logic signed [AW-1:0]   acc;

    logic                   tick;
    logic                   sweep_entry;
    logic [5:0]             inc;
    logic [TW-1:0]          tri_val;
    logic signed [TW-1:0]   s_val, x_val;
    logic signed [AW-1:0]   x_ext, v_val, acc_nxt;

    // Mode register: remembers last cycle's mode so SWEEP entry can be seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Mode decode, strobe timing and the modulator datapath.
    always_comb begin
        state_nxt   = IDLE;
        if (en) state_nxt = sweep ? SWEEP : FIXED;
        tick        = (state_nxt != IDLE) && (div_cnt == DCW'(DIV - 1));
        sweep_entry = (state_nxt == SWEEP) && (state != SWEEP);
        inc         = (state_nxt == SWEEP) ? step_idx : freq_word;
        // Fold the upper half of the phase to get a rising/falling ramp.
        tri_val     = phase[PHASE_W-1] ? ~phase[TW-1:0] : phase[TW-1:0];
        // Subtracting half scale in TW bits is just an MSB flip.
        s_val       = {~tri_val[TW-1], tri_val[TW-2:0]};
        x_val       = s_val >>> amp;
        x_ext       = {{(AW - TW){x_val[TW-1]}}, x_val};
        v_val       = acc + x_ext;
        acc_nxt     = v_val[AW-1] ? (v_val + HALF) : (v_val - HALF);
    end

    // Divider, phase/modulator update and sweep stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            dwell_cnt  <= '0;
            phase      <= '0;
            acc        <= '0;
            ds_out     <= 1'b0;
            sample_stb <= 1'b0;
            sweep_wrap <= 1'b0;
            step_idx   <= '0;
        end else if (state_nxt == IDLE) begin
            div_cnt    <= '0;
            dwell_cnt  <= '0;
            phase      <= '0;
            acc        <= '0;
            ds_out     <= 1'b0;
            sample_stb <= 1'b0;
            sweep_wrap <= 1'b0;
        end else begin
            sample_stb <= tick;
            sweep_wrap <= 1'b0;
            div_cnt    <= tick ? '0 : div_cnt + DCW'(1);
            if (tick) begin
                // Modulator reads the pre-increment phase.
                phase  <= phase + {{(PHASE_W - 6){1'b0}}, inc};
                acc    <= acc_nxt;
                ds_out <= ~v_val[AW-1];
            end
            if (state_nxt == FIXED) begin
                step_idx <= freq_word;
            end else if (sweep_entry) begin
                step_idx  <= 6'd1;
                dwell_cnt <= '0;
            end else if (tick) begin
                if (dwell_cnt == DWW'(DWELL - 1)) begin
                    dwell_cnt <= '0;
                    if (step_idx == 6'd63) begin
                        step_idx   <= 6'd1;   // step 0 would be a DC tone
                        sweep_wrap <= 1'b1;
                    end else begin
                        step_idx <= step_idx + 6'd1;
                    end
                end else begin
                    dwell_cnt <= dwell_cnt + DWW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ds_tone_gen.sv
// Bench for ds_tone_gen: per-cycle comparison against an integer reference
// model, plus directed checks of strobe timing, bit density and sweep wrap.
module tb_ds_tone_gen;

    localparam int DIV   = 32;
    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sweep = 1'b0;
    logic [5:0] freq_word = '0;
    logic [1:0] amp = '0;
    logic       ds_out, sample_stb, sweep_wrap;
    logic [5:0] step_idx;

    int n_pass = 0;
    int n_total = 0;

    // reference model state, plain integers
    int m_cnt, m_phase, m_acc, m_dwell, m_step;
    bit m_ds, m_stb, m_wrap, m_insweep;

    ds_tone_gen #(.DIV(DIV), .PHASE_W(12), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sweep(sweep),
        .freq_word(freq_word), .amp(amp), .ds_out(ds_out),
        .sample_stb(sample_stb), .step_idx(step_idx), .sweep_wrap(sweep_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void model_reset();
        m_cnt = 0; m_phase = 0; m_acc = 0; m_dwell = 0; m_step = 0;
        m_ds = 0; m_stb = 0; m_wrap = 0; m_insweep = 0;
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    function automatic void model_step();
        bit strobe;
        int t, x, v, inc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!en) begin
            m_cnt = 0; m_phase = 0; m_acc = 0; m_dwell = 0;
            m_ds = 0; m_stb = 0; m_wrap = 0; m_insweep = 0;
            return;
        end
        strobe = (m_cnt == DIV - 1);
        m_cnt  = strobe ? 0 : m_cnt + 1;
        m_stb  = strobe;
        m_wrap = 0;
        if (strobe) begin
            inc = sweep ? m_step : int'(freq_word);
            t = (m_phase >= 2048) ? 4095 - m_phase : m_phase;
            x = (t - 1024) >>> amp;
            v = m_acc + x;
            m_ds = (v >= 0);
            m_acc = (v >= 0) ? v - 1024 : v + 1024;
            m_phase = (m_phase + inc) % 4096;
        end
        if (!sweep) begin
            m_step = int'(freq_word);
        end else if (!m_insweep) begin
            m_step = 1; m_dwell = 0;
        end else if (strobe) begin
            if (m_dwell == DWELL - 1) begin
                m_dwell = 0;
                m_wrap = (m_step == 63);
                m_step = (m_step == 63) ? 1 : m_step + 1;
            end else begin
                m_dwell++;
            end
        end
        m_insweep = sweep;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("ds_out", 128'(ds_out), 128'(m_ds));
        chk("sample_stb", 128'(sample_stb), 128'(m_stb));
        chk("step_idx", 128'(step_idx), 128'(m_step));
        chk("sweep_wrap", 128'(sweep_wrap), 128'(m_wrap));
    endtask

    // Run until n strobes are seen (bounded); collect ones, wraps, bit pattern.
    task automatic run_strobes(input int n, output int ones, output int wraps,
                               output logic [127:0] pat);
        int seen = 0;
        int budget = n * DIV + 2 * DIV;
        ones = 0; wraps = 0; pat = '0;
        while (seen < n && budget > 0) begin
            tick();
            if (sweep_wrap) wraps++;
            if (sample_stb) begin
                if (seen < 128) pat[seen] = ds_out;
                ones += int'(ds_out);
                seen++;
            end
            budget--;
        end
        if (seen < n) chk("strobe_timeout", 128'(seen), 128'(n));
    endtask

    initial begin
        int ones, wraps, first, second, len;
        logic [127:0] pat1, pat2;
        model_reset();

        // reset state, then release
        repeat (3) tick();
        chk("reset_ds", 128'(ds_out), 128'(0));
        chk("reset_step", 128'(step_idx), 128'(0));
        rst_n = 1'b1;
        en = 1'b1;
        repeat (10) tick();

        // async reset mid-period with en held high
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_ds", 128'(ds_out), 128'(0));
        chk("async_rst_stb", 128'(sample_stb), 128'(0));
        chk("async_rst_step", 128'(step_idx), 128'(0));
        chk("async_rst_wrap", 128'(sweep_wrap), 128'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        first = -1; second = -1;
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (sample_stb && first < 0) first = c;
            else if (sample_stb && second < 0) second = c;
        end
        chk("first_stb_latency", 128'(first), 128'(DIV));
        chk("second_stb_latency", 128'(second), 128'(2 * DIV));

        // freq 0, amp 0 already ran: all zeros; keep going 64 strobes
        run_strobes(64, ones, wraps, pat1);
        chk("fw0_amp0_ones", 128'(ones), 128'(0));

        // freq 0, amp 1: x = -512 gives one 1 in every 4 bits
        amp = 2'd1;
        run_strobes(64, ones, wraps, pat1);
        chk("fw0_amp1_ones", 128'(ones), 128'(16));

        // freq 32: density ~1/2 over each full phase cycle
        en = 1'b0; amp = 2'd0; freq_word = 6'd32;
        tick();
        en = 1'b1;
        run_strobes(128, ones, wraps, pat1);
        chk("fw32_win1_ones_ok", 128'(ones >= 63 && ones <= 65), 128'(1));
        run_strobes(128, ones, wraps, pat2);
        chk("fw32_win2_ones_ok", 128'(ones >= 63 && ones <= 65), 128'(1));

        // sweep: full pass of 63 steps, wraps exactly at the 252nd strobe
        sweep = 1'b1;
        tick();
        chk("sweep_entry_step", 128'(step_idx), 128'(1));
        run_strobes(252, ones, wraps, pat1);
        chk("sweep_wrap_count", 128'(wraps), 128'(1));
        chk("sweep_wrap_pulse", 128'(sweep_wrap), 128'(1));
        chk("sweep_wrap_step", 128'(step_idx), 128'(1));
        run_strobes(10, ones, wraps, pat1);
        sweep = 1'b0;
        repeat (3) tick();
        sweep = 1'b1;
        tick();
        chk("sweep_restart_step", 128'(step_idx), 128'(1));

        // one-cycle en drop mid-period restarts the output sequence identically
        sweep = 1'b0; freq_word = 6'd5; amp = 2'd2;
        repeat (7) tick();
        en = 1'b0;
        tick();
        chk("gap_stb", 128'(sample_stb), 128'(0));
        en = 1'b1;
        run_strobes(40, ones, wraps, pat1);
        repeat (11) tick();
        en = 1'b0;
        tick();
        en = 1'b1;
        run_strobes(40, ones, wraps, pat2);
        chk("restart_pattern", pat2 & ((128'(1) << 40) - 1), pat1 & ((128'(1) << 40) - 1));

        // randomized segments, checked every cycle against the model
        for (int seg = 0; seg < 30; seg++) begin
            en = ($urandom_range(0, 7) != 0);
            sweep = ($urandom_range(0, 2) == 0);
            freq_word = 6'($urandom);
            amp = 2'($urandom);
            len = $urandom_range(1, 300);
            if ($urandom_range(0, 9) == 0) begin
                #3 rst_n = 1'b0;
                #1;
                model_reset();
                chk("rand_rst_stb", 128'(sample_stb), 128'(0));
                tick();
                rst_n = 1'b1;
            end
            repeat (len) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
